gb_processor: RTL and testbench

- Single-issue 8-bit processor core executing a Game Boy (SM83) register-only instruction subset: 8-bit ALU ops and register-to-register loads.
- One opcode is presented per cycle with a valid strobe.
- The full architectural register file is exposed on a probe bus so the bench can check results directly.
- No memory interface; `(HL)`-operand encodings are no-ops.

---
 rtl/gb_processor.sv | 189 ++++++++++++++++++
 tb/tb_gb_processor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gb_processor.sv
// gb_processor: single-issue 8-bit core running the SM83 register-only subset
// (8-bit ALU ops on A and register-to-register loads). One opcode per cycle,
// qualified by valid; the result is architecturally visible one edge later.
// (HL)-operand encodings, HALT and every unsupported opcode leave state alone.
//
// Optional feature: define GBP_INCDEC_EN to execute INC r / DEC r
// (00rrr100 / 00rrr101). When undefined those opcodes are no-ops.
//
// Ports:
//   clock       in   1  rising-edge clock
//   reset       in   1  synchronous, active-high; wins over valid
//   instruction in   8  opcode, sampled when valid=1
//   valid       in   1  qualifies instruction this cycle
//   probe       out 64  {A,F,B,C,D,E,H,L}
module gb_processor (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  instruction,
  input  logic        valid,
  output logic [63:0] probe
);

  logic [7:0] a_q, f_q, b_q, c_q, d_q, e_q, h_q, l_q;
  logic [7:0] a_d, f_d, b_d, c_d, d_d, e_d, h_d, l_d;

  logic [7:0]  src_val;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [7:0]  wr_val;
  logic [15:0] alu_out;

  // Returns {result[7:0], Z, N, H, C, 4'b0}.
  function automatic logic [15:0] alu(input logic [2:0] opsel,
                                      input logic [7:0] a,
                                      input logic [7:0] s,
                                      input logic       cin);
    logic [8:0] sum;
    logic [4:0] nib;
    logic [7:0] r;
    logic       ci, n, h, c;
    ci  = (opsel == 3'd1 || opsel == 3'd3) ? cin : 1'b0;
    sum = '0;
    nib = '0;
    r   = '0;
    n   = 1'b0;
    h   = 1'b0;
    c   = 1'b0;
    case (opsel)
      3'd0, 3'd1: begin
        sum = {1'b0, a} + {1'b0, s} + {8'b0, ci};
        nib = {1'b0, a[3:0]} + {1'b0, s[3:0]} + {4'b0, ci};
        r   = sum[7:0];
        h   = nib[4];
        c   = sum[8];
      end
      3'd2, 3'd3, 3'd7: begin
        // A negative 9-/5-bit difference sets the top bit: that is the borrow.
        sum = {1'b0, a} - {1'b0, s} - {8'b0, ci};
        nib = {1'b0, a[3:0]} - {1'b0, s[3:0]} - {4'b0, ci};
        r   = sum[7:0];
        n   = 1'b1;
        h   = nib[4];
        c   = sum[8];
      end
      3'd4: begin
        r = a & s;
        h = 1'b1;
      end
      3'd5: r = a ^ s;
      default: r = a | s;
    endcase
    return {r, (r == 8'h00), n, h, c, 4'b0000};
  endfunction

`ifdef GBP_INCDEC_EN
  // Returns {result[7:0], Z, N, H, C, 4'b0}; carry passes through untouched.
  function automatic logic [15:0] incdec(input logic       is_dec,
                                         input logic [7:0] v,
                                         input logic       cin);
    logic [7:0] r;
    logic       h;
    if (is_dec) begin
      r = v - 8'd1;
      h = (v[3:0] == 4'h0);
    end else begin
      r = v + 8'd1;
      h = (v[3:0] == 4'hF);
    end
    return {r, (r == 8'h00), is_dec, h, cin, 4'b0000};
  endfunction
`endif

  always_comb begin
    case (instruction[2:0])
      3'd0:    src_val = b_q;
      3'd1:    src_val = c_q;
      3'd2:    src_val = d_q;
      3'd3:    src_val = e_q;
      3'd4:    src_val = h_q;
      3'd5:    src_val = l_q;
      3'd7:    src_val = a_q;
      default: src_val = 8'h00;
    endcase
  end

  always_comb begin
    a_d = a_q;
    f_d = f_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    e_d = e_q;
    h_d = h_q;
    l_d = l_q;
    wr_en   = 1'b0;
    wr_idx  = instruction[5:3];
    wr_val  = src_val;
    alu_out = alu(instruction[5:3], a_q, src_val, f_q[4]);

    if (valid) begin
      if (instruction[7:6] == 2'b01) begin
        // Register load; any (HL) index, including HALT, does nothing.
        wr_en = (instruction[5:3] != 3'd6) && (instruction[2:0] != 3'd6);
      end else if (instruction[7:6] == 2'b10) begin
        if (instruction[2:0] != 3'd6) begin
          f_d    = alu_out[7:0];
          wr_en  = (instruction[5:3] != 3'd7);  // CP leaves A alone
          wr_idx = 3'd7;
          wr_val = alu_out[15:8];
        end
      end
`ifdef GBP_INCDEC_EN
      else if (instruction[7:6] == 2'b00 && instruction[2:1] == 2'b10 &&
               instruction[5:3] != 3'd6) begin
        case (instruction[5:3])
          3'd0:    alu_out = incdec(instruction[0], b_q, f_q[4]);
          3'd1:    alu_out = incdec(instruction[0], c_q, f_q[4]);
          3'd2:    alu_out = incdec(instruction[0], d_q, f_q[4]);
          3'd3:    alu_out = incdec(instruction[0], e_q, f_q[4]);
          3'd4:    alu_out = incdec(instruction[0], h_q, f_q[4]);
          3'd5:    alu_out = incdec(instruction[0], l_q, f_q[4]);
          default: alu_out = incdec(instruction[0], a_q, f_q[4]);
        endcase
        f_d    = alu_out[7:0];
        wr_en  = 1'b1;
        wr_val = alu_out[15:8];
      end
`endif
    end

    if (wr_en) begin
      case (wr_idx)
        3'd0:    b_d = wr_val;
        3'd1:    c_d = wr_val;
        3'd2:    d_d = wr_val;
        3'd3:    e_d = wr_val;
        3'd4:    h_d = wr_val;
        3'd5:    l_d = wr_val;
        3'd7:    a_d = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= 8'h01;
      f_q <= 8'hB0;
      b_q <= 8'h00;
      c_q <= 8'h13;
      d_q <= 8'h00;
      e_q <= 8'hD8;
      h_q <= 8'h01;
      l_q <= 8'h4D;
    end else begin
      a_q <= a_d;
      f_q <= f_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      e_q <= e_d;
      h_q <= h_d;
      l_q <= l_d;
    end
  end

  assign probe = {a_q, f_q, b_q, c_q, d_q, e_q, h_q, l_q};

endmodule

// File: tb/tb_gb_processor.sv
// Bench for gb_processor: a directed vector table followed by randomized
// opcodes compared every cycle against a behavioural register model.
module tb_gb_processor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  instruction = 8'h00;
  logic        valid = 1'b0;
  logic [63:0] probe;

  localparam logic [63:0] RST_PROBE = 64'h01B0_0013_00D8_014D;

  gb_processor dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .valid       (valid),
    .probe       (probe)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  op;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Reference model: registers indexed as in the opcode (7=A, 6 unused).
  logic [7:0] m [8];
  logic [7:0] mf;

  task automatic model_reset();
    m[7] = 8'h01; mf = 8'hB0; m[0] = 8'h00; m[1] = 8'h13;
    m[2] = 8'h00; m[3] = 8'hD8; m[4] = 8'h01; m[5] = 8'h4D; m[6] = 8'h00;
  endtask

  function automatic logic [63:0] model_probe();
    return {m[7], mf, m[0], m[1], m[2], m[3], m[4], m[5]};
  endfunction

  task automatic model_step(input logic rst, input logic v, input logic [7:0] op);
    int a, s, cin, res, h, c, n, kind, dst, src;
    if (rst) begin
      model_reset();
      return;
    end
    if (!v) return;
    kind = int'(op) / 64;
    dst  = (int'(op) / 8) % 8;
    src  = int'(op) % 8;
    if (kind == 1) begin
      if (dst != 6 && src != 6) m[dst] = m[src];
    end else if (kind == 2) begin
      if (src == 6) return;
      a = int'(m[7]); s = int'(m[src]); cin = int'(mf[4]);
      h = 0; c = 0; n = 0; res = 0;
      case (dst)
        0, 1: begin
          if (dst == 0) cin = 0;
          res = a + s + cin;
          h = ((a % 16) + (s % 16) + cin > 15) ? 1 : 0;
          c = (res > 255) ? 1 : 0;
        end
        2, 3, 7: begin
          if (dst != 3) cin = 0;
          n = 1;
          res = a - s - cin;
          h = ((a % 16) - (s % 16) - cin < 0) ? 1 : 0;
          c = (res < 0) ? 1 : 0;
        end
        4: begin res = a & s; h = 1; end
        5: res = a ^ s;
        default: res = a | s;
      endcase
      res = res & 255;
      mf = {(res == 0), n[0], h[0], c[0], 4'b0000};
      if (dst != 7) m[7] = 8'(res);
    end
`ifdef GBP_INCDEC_EN
    else if (kind == 0 && (src == 4 || src == 5) && dst != 6) begin
      a = int'(m[dst]);
      if (src == 4) begin
        res = (a + 1) & 255;
        h = (a % 16 == 15) ? 1 : 0;
        n = 0;
      end else begin
        res = (a + 255) & 255;
        h = (a % 16 == 0) ? 1 : 0;
        n = 1;
      end
      mf = {(res == 0), n[0], h[0], mf[4], 4'b0000};
      m[dst] = 8'(res);
    end
`endif
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [7:0] op);
    reset = rst;
    valid = vld;
    instruction = op;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] inc_exp, dec_exp;
`ifdef GBP_INCDEC_EN
    inc_exp = 64'h0110_0113_00D8_014D;
    dec_exp = 64'h01D0_0013_00D8_014D;
`else
    inc_exp = RST_PROBE;
    dec_exp = RST_PROBE;
`endif
    vecs.push_back('{1'b1, 1'b0, 8'h00, RST_PROBE, "reset"});
    vecs.push_back('{1'b0, 1'b0, 8'h80, RST_PROBE, "idle1"});
    vecs.push_back('{1'b0, 1'b0, 8'h80, RST_PROBE, "idle2"});
    vecs.push_back('{1'b0, 1'b0, 8'h80, RST_PROBE, "idle3"});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 64'h0100_0013_00D8_014D, "add_a_b"});
    vecs.push_back('{1'b0, 1'b1, 8'hAF, 64'h0080_0013_00D8_014D, "xor_a_a"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, RST_PROBE, "reset2"});
    vecs.push_back('{1'b0, 1'b1, 8'h7B, 64'hD8B0_0013_00D8_014D, "ld_a_e"});
    vecs.push_back('{1'b0, 1'b1, 8'h87, 64'hB030_0013_00D8_014D, "add_a_a"});
    vecs.push_back('{1'b0, 1'b0, 8'h87, 64'hB030_0013_00D8_014D, "idle_hold"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, RST_PROBE, "reset3"});
    vecs.push_back('{1'b0, 1'b1, 8'hB9, 64'h0170_0013_00D8_014D, "cp_a_c"});
    vecs.push_back('{1'b0, 1'b1, 8'hA4, 64'h0120_0013_00D8_014D, "and_a_h"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, RST_PROBE, "reset4"});
    vecs.push_back('{1'b0, 1'b1, 8'h97, 64'h00C0_0013_00D8_014D, "sub_a_a"});
    vecs.push_back('{1'b0, 1'b1, 8'h46, 64'h00C0_0013_00D8_014D, "ld_b_hl_nop"});
    vecs.push_back('{1'b0, 1'b1, 8'h76, 64'h00C0_0013_00D8_014D, "halt_nop"});
    vecs.push_back('{1'b0, 1'b1, 8'h86, 64'h00C0_0013_00D8_014D, "add_hl_nop"});
    vecs.push_back('{1'b1, 1'b1, 8'h80, RST_PROBE, "reset_beats_valid"});
    vecs.push_back('{1'b0, 1'b1, 8'h88, 64'h0200_0013_00D8_014D, "adc_a_b"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, RST_PROBE, "reset5"});
    vecs.push_back('{1'b0, 1'b1, 8'h98, 64'h00C0_0013_00D8_014D, "sbc_a_b"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, RST_PROBE, "reset6"});
    vecs.push_back('{1'b0, 1'b1, 8'h04, inc_exp, "inc_b"});
    vecs.push_back('{1'b0, 1'b1, 8'h05, dec_exp, "dec_b"});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].op);
      check(vecs[i].name, probe, vecs[i].exp);
    end

    // Randomized phase, starting from a reset so model and DUT agree.
    for (int i = 0; i < 3000; i++) begin
      logic       r, v;
      logic [7:0] op;
      r  = (i == 0) || ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 7) != 0);
      op = 8'($urandom_range(0, 255));
      drive(r, v, op);
      model_step(r, v, op);
      check($sformatf("rand%0d_op%02h_v%0d_r%0d", i, op, v, r), probe, model_probe());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
